// File: rtl/sorter_defs.sv
// Shared definitions for the merge sorter tree: geometry, the end-of-run sentinel,
// and the state encodings of the root output collector.
package sorter_defs;
    localparam int W          = 32;
    localparam int LEAF_WORDS = 16;
    localparam int NUM_LEAVES = 8;
    localparam int TOTAL      = LEAF_WORDS * NUM_LEAVES;
    localparam logic [W-1:0] SENTINEL = {W{1'b1}};

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/out_reg_stage.sv
// One-entry valid/ready output register: load wins over accept, so a
// same-cycle accept+load keeps valid high and replaces the data.
module out_reg_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/output_collector.sv
// Root drain stage of the merge sorter: forwards TOTAL sorted words to the sink,
// then consumes and checks the end-of-run sentinel and reports done/errors.
module output_collector
    import sorter_defs::*;
#(
    parameter int W     = sorter_defs::W,
    parameter int TOTAL = sorter_defs::TOTAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] r_dout,
    input  logic         r_empty,
    output logic         r_deq,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         done,
    output logic         sort_err,
    output logic         sent_err
);

    localparam int CW = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TOTAL);
    localparam logic [W-1:0]  SENT    = {W{1'b1}};

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  last;
    logic          load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= ST_DRAIN;
        else if (clr) state <= ST_DRAIN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DRAIN: if (cnt == CNT_MAX) state_nxt = ST_FLUSH;
            ST_FLUSH: if (!r_empty)       state_nxt = ST_WAIT;
            ST_WAIT:  if (!o_valid)       state_nxt = ST_DONE;
            default:  state_nxt = ST_DONE;
        endcase
    end

    // The sentinel pop in FLUSH does not touch the output register, so it
    // needs no sink-side gating.
    always_comb begin
        r_deq = 1'b0;
        case (state)
            ST_DRAIN: r_deq = !r_empty && (!o_valid || o_ready) && (cnt < CNT_MAX);
            ST_FLUSH: r_deq = !r_empty;
            default:  r_deq = 1'b0;
        endcase
    end

    assign load = (state == ST_DRAIN) && r_deq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            last     <= '0;
            done     <= 1'b0;
            sort_err <= 1'b0;
            sent_err <= 1'b0;
        end else if (clr) begin
            cnt      <= '0;
            last     <= '0;
            done     <= 1'b0;
            sort_err <= 1'b0;
            sent_err <= 1'b0;
        end else begin
            if (load) begin
                cnt  <= cnt + CW'(1);
                last <= r_dout;
                if (cnt != '0 && r_dout < last) sort_err <= 1'b1;
            end
            if (state == ST_FLUSH && r_deq && r_dout != SENT) sent_err <= 1'b1;
            if (state == ST_WAIT && !o_valid) done <= 1'b1;
        end
    end

    out_reg_stage #(.W(W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (load),
        .load_data (r_dout),
        .ready     (o_ready),
        .data      (o_data),
        .valid     (o_valid)
    );

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: a queue-backed root FIFO and sink, with a stream-level
// scoreboard (forwarded words, sticky order/sentinel flags, run completion).
module tb_output_collector;

    localparam int          TOT  = 128;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [31:0] r_dout, o_data;
    logic        r_empty, r_deq, o_valid, o_ready, done, sort_err, sent_err;

    int          checks = 0;
    int          errors = 0;
    int          mode   = 0;
    logic [31:0] src[$];
    logic [31:0] exp_w[$];
    logic [31:0] got[$];
    int          pops;
    bit          exp_sort, exp_sent, stalled;
    logic [31:0] held, prev_w;

    output_collector dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .r_dout   (r_dout),
        .r_empty  (r_empty),
        .r_deq    (r_deq),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .done     (done),
        .sort_err (sort_err),
        .sent_err (sent_err)
    );

    always #5 clk = ~clk;

    function automatic bit rdy(input int m, input int c);
        if (m == 0) return 1'b1;
        if (m == 1) return (c % 4 == 0) || (c % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Any strict decrease between neighbours of the expected data stream.
    function automatic bit has_inversion();
        for (int i = 1; i < TOT; i++)
            if (exp_w[i] < exp_w[i-1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int word_mismatches();
        int n = 0;
        if (got.size() != TOT) return TOT;
        for (int i = 0; i < TOT; i++)
            if (got[i] !== exp_w[i]) n++;
        return n;
    endfunction

    task automatic drive_fifo();
        bit avail;
        avail   = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        r_empty = !(avail && src.size() > 0);
        r_dout  = (src.size() > 0) ? src[0] : $urandom();
    endtask

    task automatic model_clear();
        got.delete();
        pops     = 0;
        exp_sort = 1'b0;
        exp_sent = 1'b0;
        stalled  = 1'b0;
        prev_w   = '0;
    endtask

    task automatic gen_sorted(input int n_real);
        logic [31:0] v;
        exp_w.delete();
        v = $urandom_range(0, 1000);
        for (int i = 0; i < TOT; i++) begin
            v += $urandom_range(0, 3);
            exp_w.push_back(i < n_real ? v : SENT);
        end
    endtask

    task automatic load_run(input logic [31:0] tail, input logic [31:0] extra);
        for (int i = 0; i < TOT; i++) src.push_back(exp_w[i]);
        src.push_back(tail);
        src.push_back(extra);
        o_ready = rdy(mode, 0);
        drive_fifo();
    endtask

    task automatic do_clr();
        src.delete();
        drive_fifo();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
    endtask

    // Cycle driver: sink/FIFO handshakes plus per-cycle protocol and sticky-flag checks.
    task automatic run(input int budget, input int stop_pops, output int acc_step, output int done_step);
        bit          deq;
        logic [31:0] w;
        acc_step  = -1;
        done_step = -1;
        for (int c = 0; c < budget; c++) begin
            if (done_step >= 0 && c > done_step + 5) break;
            if (stop_pops > 0 && pops >= stop_pops) break;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== held) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", o_valid, o_data, held);
                end
            end
            stalled = o_valid && !o_ready;
            held    = o_data;
            if (o_valid === 1'b1 && o_ready) begin
                got.push_back(o_data);
                if (got.size() == TOT) acc_step = c;
            end
            if (done === 1'b1 && done_step < 0) begin
                done_step = c;
                checks++;
                if (got.size() != TOT) begin
                    errors++;
                    $display("FAIL early_done: accepted=%0d, required %0d", got.size(), TOT);
                end
            end
            deq = (r_deq === 1'b1);
            checks++;
            if (deq && (r_empty || pops > TOT)) begin
                errors++;
                $display("FAIL illegal_pop: r_deq=1 with empty=%b pops=%0d, required r_deq=0", r_empty, pops);
            end
            @(posedge clk);
            #1;
            if (deq && src.size() > 0) begin
                w = src.pop_front();
                if (pops > 0 && pops < TOT && w < prev_w) exp_sort = 1'b1;
                if (pops == TOT && w !== SENT) exp_sent = 1'b1;
                prev_w = w;
                pops++;
            end
            o_ready = rdy(mode, c + 1);
            drive_fifo();
            checks += 2;
            if (sort_err !== exp_sort) begin
                errors++;
                $display("FAIL sort_err_track: got %b, required %b (pops=%0d)", sort_err, exp_sort, pops);
            end
            if (sent_err !== exp_sent) begin
                errors++;
                $display("FAIL sent_err_track: got %b, required %b (pops=%0d)", sent_err, exp_sent, pops);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; o_ready = 1'b0;
        src.delete();
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_data, done, sort_err, sent_err, r_deq} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h done=%b se=%b te=%b deq=%b, required all 0",
                     o_valid, o_data, done, sort_err, sent_err, r_deq);
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_ramp();
        int a, d, nbad;
        mode = 0;
        do_clr();
        exp_w.delete();
        for (int i = 0; i < TOT; i++) exp_w.push_back(32'(i));
        load_run(SENT, 32'h0000_1234);
        run(600, 0, a, d);
        nbad = word_mismatches();
        checks += 4;
        if (nbad != 0) begin errors++; $display("FAIL ramp_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if (a != TOT) begin errors++; $display("FAIL ramp_throughput: last word accepted at cycle %0d, required %0d", a, TOT); end
        if (d < 0 || d <= a || d > a + 4) begin errors++; $display("FAIL ramp_done: done at cycle %0d, last accept %0d", d, a); end
        if ({done, sort_err, sent_err} !== 3'b100 || src.size() != 1) begin
            errors++;
            $display("FAIL ramp_flags: done=%b se=%b te=%b left=%0d, required 1 0 0 left=1", done, sort_err, sent_err, src.size());
        end
    endtask

    task automatic test_backpressure();
        int a, d, nbad;
        mode = 1;
        do_clr();
        gen_sorted(TOT);
        load_run(SENT, 32'h5555_0000);
        run(2000, 0, a, d);
        nbad = word_mismatches();
        checks += 2;
        if (nbad != 0) begin errors++; $display("FAIL bp_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if ({done, sort_err, sent_err} !== 3'b100) begin
            errors++;
            $display("FAIL bp_flags: done=%b se=%b te=%b, required 1 0 0", done, sort_err, sent_err);
        end
    endtask

    task automatic test_order_fault();
        int a, d, nbad;
        mode = 0;
        do_clr();
        exp_w.delete();
        for (int i = 0; i < TOT; i++) exp_w.push_back(i < 5 ? 32'(2 * i) : 32'(20 + i));
        exp_w[5] = 32'd10;
        exp_w[6] = 32'd9;
        load_run(SENT, 32'h0);
        run(600, 0, a, d);
        nbad = word_mismatches();
        checks += 2;
        if (nbad != 0) begin errors++; $display("FAIL order_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if ({done, sort_err, sent_err} !== {1'b1, has_inversion(), 1'b0}) begin
            errors++;
            $display("FAIL order_flags: done=%b se=%b te=%b, required 1 1 0", done, sort_err, sent_err);
        end
    endtask

    task automatic test_bad_sentinel();
        int a, d, nbad;
        mode = 2;
        do_clr();
        gen_sorted(TOT);
        load_run(32'h0000_0007, 32'hCAFE_0130);
        run(2000, 0, a, d);
        nbad = word_mismatches();
        checks += 3;
        if (nbad != 0) begin errors++; $display("FAIL badsent_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if ({done, sort_err, sent_err} !== 3'b101) begin
            errors++;
            $display("FAIL badsent_flags: done=%b se=%b te=%b, required 1 0 1", done, sort_err, sent_err);
        end
        if (src.size() != 1 || src[0] !== 32'hCAFE_0130) begin
            errors++;
            $display("FAIL badsent_left: %0d words left in FIFO, required 1 (word 130)", src.size());
        end
    endtask

    task automatic test_ff_data();
        int a, d, nbad;
        mode = 2;
        do_clr();
        gen_sorted(120);
        load_run(SENT, 32'h1);
        run(2000, 0, a, d);
        nbad = word_mismatches();
        checks += 2;
        if (nbad != 0) begin errors++; $display("FAIL ffdata_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if ({done, sort_err, sent_err} !== 3'b100) begin
            errors++;
            $display("FAIL ffdata_flags: done=%b se=%b te=%b, required 1 0 0", done, sort_err, sent_err);
        end
    endtask

    task automatic test_rst_midrun();
        int a, d, nbad;
        mode = 2;
        do_clr();
        gen_sorted(TOT);
        load_run(SENT, 32'h2);
        run(2000, 50, a, d);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_data, done, sort_err, sent_err} !== '0) begin
            errors++;
            $display("FAIL async_rst: valid=%b data=%h done=%b se=%b te=%b, required all 0",
                     o_valid, o_data, done, sort_err, sent_err);
        end
        src.delete();
        model_clear();
        drive_fifo();
        @(posedge clk);
        #1 rst = 1'b0;
        gen_sorted(TOT);
        load_run(SENT, 32'h3);
        run(2000, 0, a, d);
        nbad = word_mismatches();
        checks += 2;
        if (nbad != 0) begin errors++; $display("FAIL rerun_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if ({done, sort_err, sent_err} !== 3'b100) begin
            errors++;
            $display("FAIL rerun_flags: done=%b se=%b te=%b, required 1 0 0", done, sort_err, sent_err);
        end
        do_clr();
        checks++;
        if ({done, o_valid, sort_err, sent_err} !== 4'b0000) begin
            errors++;
            $display("FAIL clr_rearm: done=%b valid=%b se=%b te=%b, required all 0", done, o_valid, sort_err, sent_err);
        end
        mode = 0;
        gen_sorted(TOT);
        load_run(SENT, 32'h4);
        run(600, 0, a, d);
        nbad = word_mismatches();
        checks += 2;
        if (nbad != 0) begin errors++; $display("FAIL clr_run_words: %0d bad of %0d accepted, required 0", nbad, got.size()); end
        if (done !== 1'b1 || a != TOT) begin
            errors++;
            $display("FAIL clr_run_done: done=%b last accept %0d, required 1 and %0d", done, a, TOT);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_order_fault();
        test_bad_sentinel();
        test_ff_data();
        test_rst_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
